decode_alu_stage: RTL

- Registered, handshaked decode stage for the integer ALU path.
- Successor to the combinational OP-IMM decoder. Covers both OP-IMM (0010011) and OP (0110011).
- Parametrised in data width (RV32/RV64 shift-amount rules). Sign-extends immediates to XLEN.
- Flags illegal encodings and keeps a saturating illegal-instruction counter.
- Sits between fetch buffer and ALU issue, using a valid/ready pipeline register.

---
 rtl/decode_alu_stage_if.sv | 32 +++
 rtl/decode_alu_stage.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/decode_alu_stage_if.sv
// Handshake and decoded-field bundle between the fetch buffer, the decode
// stage and ALU issue. The slave side is the decode stage.
interface decode_alu_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [XLEN-1:0]  out_imm;
  logic [4:0]       out_alu_control;
  logic             out_use_imm;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_count;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_rd, out_rs1, out_rs2, out_imm,
           out_alu_control, out_use_imm, out_illegal, illegal_count
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_rd, out_rs1, out_rs2, out_imm,
           out_alu_control, out_use_imm, out_illegal, illegal_count
  );
endinterface

// File: rtl/decode_alu_stage.sv
// Registered valid/ready decode stage for RV32/RV64 OP and OP-IMM words,
// with illegal-encoding detection and a saturating illegal-word counter.
module decode_alu_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  decode_alu_stage_if.slave   bus
);
  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_SLL  = 5'd2,
    ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,
    ALU_AND  = 5'd9
  } alu_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // RV64 steals instr[25] for the shift amount, shrinking the upper field.
  localparam int              SH_W   = (XLEN == 64) ? 6 : 5;
  localparam int              HI_W   = 12 - SH_W;
  localparam logic [HI_W-1:0] HI_ALT = {2'b01, {(HI_W-2){1'b0}}};

  logic [31:0]      instr;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [SH_W-1:0]  shamt;
  logic [HI_W-1:0]  shift_hi;
  logic             accept;

  alu_e             dec_alu;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_use_imm;
  logic             dec_illegal;
  logic [4:0]       dec_rd;
  logic [4:0]       dec_rs2;

  assign instr    = bus.in_instr;
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign shamt    = instr[20 +: SH_W];
  assign shift_hi = instr[31:20+SH_W];

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    dec_alu     = ALU_ADD;
    dec_imm     = '0;
    dec_use_imm = 1'b0;
    dec_illegal = 1'b0;
    dec_rd      = instr[11:7];
    dec_rs2     = instr[24:20];

    if (instr[6:0] == OPC_OP_IMM) begin
      dec_use_imm = 1'b1;
      dec_rs2     = '0;
      dec_imm     = {{(XLEN-12){instr[31]}}, instr[31:20]};
      case (funct3)
        3'd0: dec_alu = ALU_ADD;
        3'd2: dec_alu = ALU_SLT;
        3'd3: dec_alu = ALU_SLTU;
        3'd4: dec_alu = ALU_XOR;
        3'd6: dec_alu = ALU_OR;
        3'd7: dec_alu = ALU_AND;
        3'd1: begin
          dec_imm = XLEN'(shamt);
          if (shift_hi == '0) dec_alu = ALU_SLL;
          else                dec_illegal = 1'b1;
        end
        3'd5: begin
          dec_imm = XLEN'(shamt);
          if (shift_hi == '0)         dec_alu = ALU_SRL;
          else if (shift_hi == HI_ALT) dec_alu = ALU_SRA;
          else                         dec_illegal = 1'b1;
        end
      endcase
    end else if (instr[6:0] == OPC_OP) begin
      if (funct7 == F7_BASE) begin
        case (funct3)
          3'd0: dec_alu = ALU_ADD;
          3'd1: dec_alu = ALU_SLL;
          3'd2: dec_alu = ALU_SLT;
          3'd3: dec_alu = ALU_SLTU;
          3'd4: dec_alu = ALU_XOR;
          3'd5: dec_alu = ALU_SRL;
          3'd6: dec_alu = ALU_OR;
          3'd7: dec_alu = ALU_AND;
        endcase
      end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
        dec_alu = ALU_SUB;
      end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
        dec_alu = ALU_SRA;
      end else begin
        dec_illegal = 1'b1;
      end
    end else begin
      dec_illegal = 1'b1;
    end

    // Illegal words carry a harmless ADD with no destination.
    if (dec_illegal) begin
      dec_alu     = ALU_ADD;
      dec_imm     = '0;
      dec_use_imm = 1'b0;
      dec_rd      = '0;
      dec_rs2     = instr[24:20];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      bus.out_valid       <= 1'b0;
      bus.out_rd          <= '0;
      bus.out_rs1         <= '0;
      bus.out_rs2         <= '0;
      bus.out_imm         <= '0;
      bus.out_alu_control <= '0;
      bus.out_use_imm     <= 1'b0;
      bus.out_illegal     <= 1'b0;
      bus.illegal_count   <= '0;
    end else if (accept) begin
      bus.out_valid       <= 1'b1;
      bus.out_rd          <= dec_rd;
      bus.out_rs1         <= instr[19:15];
      bus.out_rs2         <= dec_rs2;
      bus.out_imm         <= dec_imm;
      bus.out_alu_control <= dec_alu;
      bus.out_use_imm     <= dec_use_imm;
      bus.out_illegal     <= dec_illegal;
      if (dec_illegal && bus.illegal_count != {CNT_W{1'b1}})
        bus.illegal_count <= bus.illegal_count + CNT_W'(1);
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule
